// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional macro DMEM_MISALIGN_CHECK_EN is consumed by dmem_responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  localparam int WORD_OFF_W = 2;

  function automatic logic is_misaligned(input logic [WORD_OFF_W-1:0] off);
    return (off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Down-counter that measures the fixed responder latency.
// Loads LATENCY-1 on start, decrements while enabled, flags done at zero.
module dmem_latency_counter
  import dmem_resp_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Count register: load, hold, or decrement toward zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else if (start) begin
      count_r <= LOAD_VAL;
    end else if (en && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == CNT_ZERO);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store per handshake, fixed latency,
// one-cycle response pulse. Define DMEM_MISALIGN_CHECK_EN to add the err output.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] din,
  output logic              is_ready,
  output logic              is_output_valid,
  output logic [DATA_W-1:0] dout
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

  state_e            state_r;
  state_e            next_state_s;
  op_e               op_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] din_r;
  logic              bad_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              accept_s;
  logic              cnt_done_s;
  logic              misalign_s;
  logic [IDX_W-1:0]  req_idx_s;
  op_e               req_op_s;
  op_e               resp_op_s;
  logic [IDX_W-1:0]  resp_idx_s;
  logic              resp_bad_s;
  logic              unused_s;

  assign req_idx_s = addr[WORD_OFF_W +: IDX_W];
  assign req_op_s  = mem_write ? OP_STORE : OP_LOAD;
  assign accept_s  = (state_r == IDLE) && is_input_valid && (mem_read ^ mem_write);
  assign unused_s  = ^addr;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_s = is_misaligned(addr[WORD_OFF_W-1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // With LATENCY=1 the response follows the accept edge directly, so the
  // request fields must be taken from the inputs rather than the latches.
  assign resp_op_s  = (state_r == IDLE) ? req_op_s   : op_r;
  assign resp_idx_s = (state_r == IDLE) ? req_idx_s  : idx_r;
  assign resp_bad_s = (state_r == IDLE) ? misalign_s : bad_r;

  dmem_latency_counter #(
    .LATENCY (LATENCY)
  ) u_latency_counter (
    .clk   (clk),
    .reset (reset),
    .start (accept_s),
    .en    (state_r == BUSY),
    .done  (cnt_done_s)
  );

  // Next-state logic for the IDLE/BUSY/RESP sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (LATENCY == 1) ? RESP : BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_done_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r         <= IDLE;
      op_r            <= OP_LOAD;
      idx_r           <= IDX_ZERO;
      din_r           <= DATA_ZERO;
      bad_r           <= 1'b0;
      is_ready        <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= DATA_ZERO;
`ifdef DMEM_MISALIGN_CHECK_EN
      err             <= 1'b0;
`endif
    end else begin
      state_r         <= next_state_s;
      is_ready        <= (next_state_s == IDLE);
      is_output_valid <= (next_state_s == RESP);
`ifdef DMEM_MISALIGN_CHECK_EN
      err             <= (next_state_s == RESP) && resp_bad_s;
`endif
      if (accept_s) begin
        op_r  <= req_op_s;
        idx_r <= req_idx_s;
        din_r <= din;
        bad_r <= misalign_s;
      end else begin
        op_r  <= op_r;
        idx_r <= idx_r;
        din_r <= din_r;
        bad_r <= bad_r;
      end
      if ((next_state_s == RESP) && (resp_op_s == OP_LOAD)) begin
        dout <= resp_bad_s ? DATA_ZERO : mem_r[resp_idx_s];
      end else begin
        dout <= dout;
      end
    end
  end

  // Storage: cleared on reset, store committed on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if ((state_r == RESP) && (op_r == OP_STORE) && !bad_r) begin
      mem_r[idx_r] <= din_r;
    end else begin
      mem_r[idx_r] <= mem_r[idx_r];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan steps followed by
// random loads/stores against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        is_input_valid = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] din = 32'd0;
  logic        is_ready;
  logic        is_output_valid;
  logic [31:0] dout;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        err;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_dout;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .err             (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    exp_dout = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    is_input_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("rst_ready", {31'd0, is_ready}, 32'd1);
    check("rst_valid", {31'd0, is_output_valid}, 32'd0);
    check("rst_dout", dout, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
  endtask

  // One full transaction: present request in IDLE, scramble inputs while busy,
  // and check pulse position, ready window and data against the model.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic bad;
    bad = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    bad = (a % 32'd4) != 32'd0;
`endif
    @(negedge clk);
    check("ready_before_req", {31'd0, is_ready}, 32'd1);
    is_input_valid = 1'b1;
    mem_read = rd;
    mem_write = wr;
    addr = a;
    din = d;
    @(posedge clk);
    for (int j = 0; j <= LATENCY + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        is_input_valid = 1'($urandom_range(0, 1));
        mem_read = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        addr = $urandom;
        din = $urandom;
      end
      if (j == LATENCY) begin
        if (rd) exp_dout = bad ? 32'd0 : model_mem[widx(a)];
        check("resp_dout", dout, exp_dout);
        is_input_valid = 1'b0;
      end
      check("valid_timing", {31'd0, is_output_valid}, (j == LATENCY) ? 32'd1 : 32'd0);
      check("ready_window", {31'd0, is_ready}, (j > LATENCY) ? 32'd1 : 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
      check("err_timing", {31'd0, err}, ((j == LATENCY) && bad) ? 32'd1 : 32'd0);
`endif
    end
    if (wr && !bad) model_mem[widx(a)] = d;
  endtask

  task automatic drop(input logic rd, input logic wr, input int cycles);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read = rd;
    mem_write = wr;
    addr = $urandom;
    din = $urandom;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      check("drop_valid", {31'd0, is_output_valid}, 32'd0);
      check("drop_ready", {31'd0, is_ready}, 32'd1);
    end
    is_input_valid = 1'b0;
  endtask

  initial begin
    model_reset();

    // Plan 1: reset state and load from a cleared word.
    do_reset();
    txn(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    check("load_0x40_zero", dout, 32'd0);

    // Plan 2: store then load with exact timing.
    txn(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D);
    txn(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    check("store_keeps_dout", dout, 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'd0);
    check("load_0x100", dout, 32'hDEAD_BEEF);

    // Plan 3: address wrap modulo DEPTH*4.
    txn(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678);
    txn(1'b1, 1'b0, 32'h0000_0000, 32'd0);
    check("wrap_load", dout, 32'h1234_5678);

    // Plan 4: malformed requests are dropped.
    drop(1'b1, 1'b1, 10);
    drop(1'b0, 1'b0, 4);

    // Plan 5: reset two cycles after accepting a store aborts it.
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    addr = 32'h0000_0020;
    din = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    is_input_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("abort_ready", {31'd0, is_ready}, 32'd1);
    check("abort_dout", dout, 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("abort_no_pulse", {31'd0, is_output_valid}, 32'd0);
    end
    txn(1'b1, 1'b0, 32'h0000_0020, 32'd0);
    check("abort_load_0x20", dout, 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
    // Plan 6: misaligned store is suppressed and flagged.
    txn(1'b0, 1'b1, 32'h0000_0022, 32'h0000_0001);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'd0);
    check("misalign_load_0x20", dout, 32'd0);
`endif

    // Random traffic over a small window of words with random upper/low bits.
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
          | 32'($urandom_range(0, 3));
      if (r == 0) begin
        drop(1'b1, 1'b1, 2);
      end else if (r == 1) begin
        drop(1'b0, 1'b0, 2);
      end else if (r < 6) begin
        txn(1'b1, 1'b0, a, 32'd0);
      end else begin
        txn(1'b0, 1'b1, a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
